// File: rtl/simd_status_ctrl.sv
// Per-channel instruction status controller: PS request edge -> decoder handshake -> sticky done/timeout flags + irq.
// Latency: request edge seen at edge N gives ins_valid/busy from N; done/timeout flags and irq from the completing edge.
// Backpressure: ins_valid holds until ins_ready; requests arriving while a channel is in ISSUE/BUSY are dropped.
module simd_status_ctrl #(
  parameter int NUM_CH    = 4,
  parameter int TIMEOUT_W = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [TIMEOUT_W-1:0] timeout_cycles,
  input  logic [NUM_CH-1:0]    in_data_valid,
  output logic [NUM_CH-1:0]    out_data_valid,
  output logic [NUM_CH-1:0]    out_err,
  output logic [NUM_CH-1:0]    busy,
  output logic [NUM_CH-1:0]    ins_valid,
  input  logic [NUM_CH-1:0]    ins_ready,
  input  logic [NUM_CH-1:0]    ins_done,
  output logic                 irq
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_BUSY  = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } state_t;

  localparam logic [TIMEOUT_W-1:0] CNT_MAX = '1;

  state_t               state     [NUM_CH];
  state_t               state_nxt [NUM_CH];
  logic [TIMEOUT_W-1:0] cnt       [NUM_CH];
  logic [TIMEOUT_W-1:0] cnt_nxt   [NUM_CH];
  logic [NUM_CH-1:0]    prev;
  logic [NUM_CH-1:0]    rise;
  logic                 armed;
  logic                 irq_nxt;

  // armed is low only for the first edge after reset, so a level already
  // high while in reset is absorbed into prev instead of looking like an edge.
  assign rise = in_data_valid & ~prev & {NUM_CH{armed}};

  // Next-state, watchdog counter and irq condition for every channel.
  always_comb begin
    irq_nxt = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      state_nxt[i] = state[i];
      cnt_nxt[i]   = cnt[i];
      case (state[i])
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (rise[i]) state_nxt[i] = ST_ISSUE;
        end
        ST_ISSUE: begin
          if (ins_ready[i]) begin
            if (ins_done[i]) begin
              state_nxt[i] = ST_DONE;
            end else begin
              state_nxt[i] = ST_BUSY;
              cnt_nxt[i]   = '0;
            end
          end
        end
        ST_BUSY: begin
          if (ins_done[i]) begin
            state_nxt[i] = ST_DONE;
          end else if ((timeout_cycles != '0) &&
                       (cnt[i] == timeout_cycles - TIMEOUT_W'(1))) begin
            state_nxt[i] = ST_ERR;
          end else if (cnt[i] != CNT_MAX) begin
            cnt_nxt[i] = cnt[i] + TIMEOUT_W'(1);
          end
        end
        default: state_nxt[i] = ST_IDLE;
      endcase
      if (((state_nxt[i] == ST_DONE) || (state_nxt[i] == ST_ERR)) &&
          !((state[i] == ST_DONE) || (state[i] == ST_ERR))) begin
        irq_nxt = 1'b1;
      end
    end
  end

  // State, counters, edge-detect history and the irq pulse register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state[i] <= ST_IDLE;
        cnt[i]   <= '0;
      end
      prev  <= '0;
      armed <= 1'b0;
      irq   <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state[i] <= state_nxt[i];
        cnt[i]   <= cnt_nxt[i];
      end
      prev  <= in_data_valid;
      armed <= 1'b1;
      irq   <= irq_nxt;
    end
  end

  // Status outputs are pure decodes of the state flops.
  always_comb begin
    out_data_valid = '0;
    out_err        = '0;
    busy           = '0;
    ins_valid      = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      out_data_valid[i] = (state[i] == ST_DONE);
      out_err[i]        = (state[i] == ST_ERR);
      ins_valid[i]      = (state[i] == ST_ISSUE);
      busy[i]           = (state[i] == ST_ISSUE) || (state[i] == ST_BUSY);
    end
  end

endmodule

// File: tb/tb_simd_status_ctrl.sv
// Bench for simd_status_ctrl: directed test-plan scenarios followed by random traffic.
// Every cycle all outputs are compared against a flag-based behavioural model.
// Includes asynchronous resets, live timeout changes and held request levels.
module tb_simd_status_ctrl;

  localparam int NCH = 4;
  localparam int TW  = 16;
  localparam int AGE_MAX = (1 << TW) - 1;

  logic           clk;
  logic           rstn;
  logic [TW-1:0]  to;
  logic [NCH-1:0] in_dv, rdy, dn;
  logic [NCH-1:0] out_dv, out_err, busy, ins_valid;
  logic           irq;

  int n_chk;
  int n_fail;

  // model: a channel is idle when none of the flags is set
  bit       m_iss [NCH];
  bit       m_run [NCH];
  bit       m_res [NCH];
  bit       m_err [NCH];
  int       m_age [NCH];
  bit [NCH-1:0] m_prev;
  bit       m_armed;
  bit       m_irq;

  simd_status_ctrl #(.NUM_CH(NCH), .TIMEOUT_W(TW)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .timeout_cycles (to),
    .in_data_valid  (in_dv),
    .out_data_valid (out_dv),
    .out_err        (out_err),
    .busy           (busy),
    .ins_valid      (ins_valid),
    .ins_ready      (rdy),
    .ins_done       (dn),
    .irq            (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_iss[c] = 0; m_run[c] = 0; m_res[c] = 0; m_err[c] = 0; m_age[c] = 0;
    end
    m_prev  = '0;
    m_armed = 0;
    m_irq   = 0;
  endtask

  task automatic model_step();
    bit any_new;
    bit r;
    bit was_fin;
    int lim;
    any_new = 0;
    lim = int'(to);
    for (int c = 0; c < NCH; c++) begin
      r = in_dv[c] && !m_prev[c] && m_armed;
      was_fin = m_res[c] || m_err[c];
      if (m_iss[c]) begin
        if (rdy[c]) begin
          m_iss[c] = 0;
          if (dn[c]) m_res[c] = 1;
          else begin m_run[c] = 1; m_age[c] = 0; end
        end
      end else if (m_run[c]) begin
        if (dn[c]) begin
          m_run[c] = 0; m_res[c] = 1;
        end else if (lim != 0 && m_age[c] == lim - 1) begin
          m_run[c] = 0; m_err[c] = 1;
        end else if (m_age[c] < AGE_MAX) begin
          m_age[c]++;
        end
      end else if (r) begin
        m_res[c] = 0; m_err[c] = 0; m_iss[c] = 1;
      end
      if ((m_res[c] || m_err[c]) && !was_fin) any_new = 1;
    end
    m_prev  = in_dv;
    m_armed = 1;
    m_irq   = any_new;
  endtask

  task automatic compare_all();
    logic [NCH-1:0] e_dv, e_err, e_busy, e_iv;
    for (int c = 0; c < NCH; c++) begin
      e_dv[c]   = m_res[c];
      e_err[c]  = m_err[c];
      e_busy[c] = m_iss[c] || m_run[c];
      e_iv[c]   = m_iss[c];
    end
    check("out_data_valid", 32'(out_dv), 32'(e_dv));
    check("out_err", 32'(out_err), 32'(e_err));
    check("busy", 32'(busy), 32'(e_busy));
    check("ins_valid", 32'(ins_valid), 32'(e_iv));
    check("irq", 32'(irq), 32'(m_irq));
  endtask

  // one clock: model advances on the edge, DUT sampled 1 time unit later
  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  // asynchronous reset pulse in mid-cycle; outputs must clear before any edge
  task automatic async_reset();
    #2;
    rstn = 1'b0;
    model_reset();
    #1;
    compare_all();
    check("rst_outputs_zero", 32'({out_dv, out_err, busy, ins_valid, irq}), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    int niv, nbusy, nirq;
    n_chk = 0; n_fail = 0;
    rstn = 1'b0; in_dv = '0; rdy = '0; dn = '0; to = '0;
    model_reset();
    #1;
    compare_all();
    #11;
    rstn = 1'b1;
    cyc(); cyc();

    // basic: ready in 2nd ISSUE cycle, done 5 cycles after acceptance
    niv = 0; nbusy = 0; nirq = 0;
    in_dv[0] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      cyc();
      if (ins_valid[0]) niv++;
      if (busy[0]) nbusy++;
      if (irq) nirq++;
      case (k)
        2: rdy[0] = 1'b1;
        3: rdy[0] = 1'b0;
        7: dn[0]  = 1'b1;
        8: dn[0]  = 1'b0;
        default: ;
      endcase
    end
    check("basic_ins_valid_cycles", 32'(niv), 32'd2);
    check("basic_busy_cycles", 32'(nbusy), 32'd7);
    check("basic_irq_cycles", 32'(nirq), 32'd1);
    check("basic_dv_held", 32'(out_dv[0]), 32'd1);

    // re-issue from DONE, then zero-latency completion in the first ISSUE cycle
    in_dv[0] = 1'b0; cyc();
    in_dv[0] = 1'b1; cyc();
    check("reissue_ins_valid", 32'(ins_valid[0]), 32'd1);
    check("reissue_dv_dropped", 32'(out_dv[0]), 32'd0);
    rdy[0] = 1'b1; dn[0] = 1'b1; cyc();
    rdy[0] = 1'b0; dn[0] = 1'b0;
    check("zlat_dv", 32'(out_dv[0]), 32'd1);
    check("zlat_busy", 32'(busy[0]), 32'd0);
    check("zlat_irq", 32'(irq), 32'd1);
    cyc();

    // watchdog with timeout 4: no done, then done on the 4th cycle
    to = 16'd4;
    for (int pass = 0; pass < 2; pass++) begin
      in_dv[0] = 1'b0; cyc();
      in_dv[0] = 1'b1; cyc();
      rdy[0] = 1'b1; cyc();
      rdy[0] = 1'b0;
      for (int j = 1; j <= 4; j++) begin
        if (pass == 1 && j == 4) dn[0] = 1'b1;
        cyc();
        dn[0] = 1'b0;
        if (j < 4) check("wd_err_early", 32'(out_err[0]), 32'd0);
      end
      check("wd_err", 32'(out_err[0]), (pass == 0) ? 32'd1 : 32'd0);
      check("wd_dv", 32'(out_dv[0]), (pass == 0) ? 32'd0 : 32'd1);
      check("wd_irq", 32'(irq), 32'd1);
    end

    // ch1 and ch3 together; rise on ch1 while BUSY is dropped
    to = '0;
    in_dv[1] = 1'b1; in_dv[3] = 1'b1; cyc();
    rdy[1] = 1'b1; rdy[3] = 1'b1; cyc();
    rdy = '0; cyc();
    in_dv[1] = 1'b0; cyc();
    in_dv[1] = 1'b1; cyc();
    check("mc_busy_rise_dropped", 32'(ins_valid[1]), 32'd0);
    dn[1] = 1'b1; dn[3] = 1'b1; cyc();
    dn = '0;
    check("mc_both_dv", 32'({out_dv[3], out_dv[1]}), 32'd3);
    check("mc_irq", 32'(irq), 32'd1);
    cyc();
    check("mc_irq_one_cycle", 32'(irq), 32'd0);

    // reset mid-BUSY with level held high
    in_dv[2] = 1'b1; cyc();
    rdy[2] = 1'b1; cyc();
    rdy = '0; cyc();
    async_reset();
    for (int k = 0; k < 4; k++) begin
      cyc();
      check("post_rst_no_issue", 32'(ins_valid[2]), 32'd0);
    end
    in_dv[2] = 1'b0; cyc();
    in_dv[2] = 1'b1; cyc();
    check("post_rst_reissue", 32'(ins_valid[2]), 32'd1);

    // random traffic
    for (int t = 0; t < 3000; t++) begin
      if (t % 64 == 0) begin
        case ($urandom_range(0, 6))
          0: to = 16'd0;
          1: to = 16'd1;
          2: to = 16'd2;
          3: to = 16'd3;
          4: to = 16'd4;
          5: to = 16'd7;
          default: to = 16'd20;
        endcase
      end
      rdy = NCH'($urandom);
      for (int c = 0; c < NCH; c++) begin
        dn[c] = ($urandom_range(0, 5) == 0);
        if ($urandom_range(0, 3) == 0) in_dv[c] = ~in_dv[c];
      end
      if ($urandom_range(0, 499) == 0) async_reset();
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/simd_status_ctrl.md
# simd_status_ctrl

Multi-channel instruction status controller between the PS-side request interface and the SIMD instruction decoder. It supports NUM_CH independent instruction slots. Each slot issues a ready/valid handshake to the decoder, tracks completion, flags a watchdog timeout, and holds a sticky result-ready flag for the PS. A single interrupt pulse reports any completion or error.

## Interface
Parameters:
- NUM_CH, 4: number of independent instruction channels (≥1).
- TIMEOUT_W, 16: width of the per-channel watchdog counter and of timeout_cycles.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rstn  in  1  reset; asynchronous, active-low.
- timeout_cycles  in  TIMEOUT_W  watchdog limit in BUSY cycles, shared by all channels; 0 disables the watchdog.
- in_data_valid  in  NUM_CH  per-channel PS request level; a request is its 0→1 edge.
- out_data_valid  out  NUM_CH  per-channel sticky result-ready flag.
- out_err  out  NUM_CH  per-channel sticky timeout flag.
- busy  out  NUM_CH  per-channel flag, high in ISSUE or BUSY.
- ins_valid  out  NUM_CH  per-channel instruction-valid to the decoder.
- ins_ready  in  NUM_CH  decoder accepts the instruction of that channel.
- ins_done  in  NUM_CH  decoder completion pulse of that channel.
- irq  out  1  one-cycle pulse when any channel enters DONE or ERR.

## Operation
- Each channel has an independent FSM with states IDLE, ISSUE, BUSY, DONE and ERR, plus a prev register for in_data_valid and a TIMEOUT_W counter.
- Rising edge: rise[i] = in_data_valid[i] & ~prev[i]. prev[i] updates every cycle.
- IDLE: rise → ISSUE.
- ISSUE: ins_valid=1.
  - ins_ready & ins_done → DONE.
  - ins_ready alone → BUSY, with the counter cleared to 0.
  - ins_done without ins_ready is ignored.
- BUSY: evaluated in priority order.
  - ins_done → DONE.
  - Else, if timeout_cycles≠0 and counter == timeout_cycles−1 → ERR.
  - Else the counter increments.
  - The counter saturates at all-ones and never wraps.
- DONE: out_data_valid=1; rise → ISSUE, and out_data_valid drops in the same cycle that ins_valid rises.
- ERR: out_err=1; rise → ISSUE, which clears out_err.
- A rise in ISSUE or BUSY is dropped and does not queue.
- ins_done in IDLE, DONE or ERR is ignored.
- ins_ready outside ISSUE is ignored.
- irq is a register. It loads the OR over channels of (next state ∈ {DONE, ERR} and current state ∉ {DONE, ERR}).
- All outputs decode directly from flops: the state register and the irq register. There are no combinational paths from inputs to outputs.
- timeout_cycles is sampled live every cycle. If it changes mid-BUSY, the new value applies from that cycle.
- Channels share only timeout_cycles and irq. Simultaneous events on different channels are fully independent.

## Timing
- Reset (rstn low, asynchronous):
  - all states are IDLE; prev, counters and irq are 0;
  - out_data_valid, out_err, busy and ins_valid are 0.
- After reset, an in_data_valid held high through reset does not issue. It must drop and rise again.
- Reset mid-operation aborts all channels immediately. In-flight ins_done pulses are lost.
- Request latency: in_data_valid rises before edge N → ins_valid and busy are high from edge N.
- Handshake: ins_valid stays high until the edge where ins_ready=1, then drops on that edge. It holds for any number of stall cycles.
- Completion: ins_done at edge K → out_data_valid high and irq high from edge K. irq lasts exactly one cycle.
- Timeout: ERR is entered at the edge ending the timeout_cycles-th BUSY cycle without ins_done. If ins_done arrives on that same edge, DONE wins.
- timeout_cycles=1: ERR is entered one cycle after acceptance if no done arrives.
- Back-to-back: a rise in the same cycle that DONE is entered is dropped, because the state is not yet DONE. A rise while in DONE re-issues with 1-cycle latency.

## Test plan
- Basic: timeout_cycles=0.
  - Stimulus: ch0 in_data_valid 0→1, ins_ready high 2 cycles later, ins_done 5 cycles after acceptance.
  - Required: ins_valid high for 2 cycles; busy for 7 cycles; then out_data_valid[0]=1 with a 1-cycle irq; out_data_valid holds until the next rise.
- Zero-latency:
  - Stimulus: ins_ready and ins_done asserted together in the first ISSUE cycle.
  - Required: DONE on that edge; ins_valid high exactly 1 cycle; never in BUSY.
- Watchdog: timeout_cycles=4, accept, no ins_done.
  - Required: out_err high exactly 4 cycles after acceptance, with irq pulsing.
  - Repeat with ins_done on the 4th cycle: required out_data_valid=1 and out_err=0.
- Multi-channel: ch1 and ch3 request on the same cycle; completions land on the same edge.
  - Required: both out_data_valid bits set and a single 1-cycle irq.
  - Required: a rise on ch1 while BUSY is dropped.
- Re-issue: rise while in DONE.
  - Required: out_data_valid drops and ins_valid rises on the same edge.
  - Required: a level held high generates no second request.
- Reset:
  - Stimulus: assert rstn low asynchronously mid-BUSY with in_data_valid held high.
  - Required: all outputs 0 immediately; no ins_valid after release until in_data_valid toggles low then high.
